// File: rtl/panel_led_shifter_pkg.sv
// Shared constants and frame helper for the front-panel LED shifter.
// State codes are plain localparam constants so legacy code can compare against them.
package panel_led_shifter_pkg;

    localparam int NBITS = 18;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_SLO   = 3'd1;
    localparam logic [2:0] ST_SHI   = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef logic [NBITS-1:0] frame_t;

    // Bit NBITS-1 goes out first and ends up at the far end of the chain.
    function automatic frame_t build_frame(
        input logic        run,
        input logic [0:4]  dsel,
        input logic [0:11] word,
        input logic        test
    );
        return test ? '1 : {run, dsel, word};
    endfunction

endpackage

// File: rtl/panel_led_shifter.sv
// Serial driver for the front-panel lamps: snapshots the display word, shifts it
// MSB-first into an external 74HC595-style chain, then strobes the storage latch.
module panel_led_shifter
    import panel_led_shifter_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] dout,
    input  logic [0:4]  dsel_led,
    input  logic        run_led,
    input  logic        lamp_test,
    output logic        sr_clk,
    output logic        sr_data,
    output logic        sr_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [7:0]  HALF_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_RELOAD  = 16'(GAP_CYCLES - 1);
    localparam logic [4:0]  LAST_BIT    = 5'(NBITS - 1);

    logic [2:0]  state;
    logic [7:0]  half_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] gap_cnt;
    frame_t      shreg;
    frame_t      frame_in;
    logic        start_load;

    assign frame_in = build_frame(run_led, dsel_led, dout, lamp_test);

    // A new frame starts when the gap expires, or straight out of LATCH when there is no gap.
    assign start_load = ((state == ST_GAP) && (gap_cnt == '0)) ||
                        ((state == ST_LATCH) && (half_cnt == '0) && (GAP_CYCLES == 0));

    // NOTE: all state and outputs update with <= so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_GAP;
            gap_cnt    <= '0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sr_clk     <= 1'b0;
            sr_data    <= 1'b0;
            sr_latch   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (start_load) begin
            state      <= ST_LOAD;
            shreg      <= frame_in;
            sr_data    <= frame_in[NBITS-1];
            bit_cnt    <= '0;
            busy       <= 1'b1;
            sr_clk     <= 1'b0;
            sr_latch   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    state    <= ST_SLO;
                    half_cnt <= HALF_RELOAD;
                end
                ST_SLO: begin
                    if (half_cnt == '0) begin
                        state    <= ST_SHI;
                        sr_clk   <= 1'b1;
                        half_cnt <= HALF_RELOAD;
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                ST_SHI: begin
                    if (half_cnt == '0) begin
                        sr_clk   <= 1'b0;
                        half_cnt <= HALF_RELOAD;
                        if (bit_cnt < LAST_BIT) begin
                            state   <= ST_SLO;
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= shreg << 1;
                            sr_data <= shreg[NBITS-2];
                        end else begin
                            state      <= ST_LATCH;
                            sr_latch   <= 1'b1;
                            frame_done <= (HALF_RELOAD == '0);
                        end
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                ST_LATCH: begin
                    // frame_done is registered, so it is raised while entering the final cycle.
                    if (half_cnt == '0) begin
                        state      <= ST_GAP;
                        gap_cnt    <= GAP_RELOAD;
                        sr_latch   <= 1'b0;
                        frame_done <= 1'b0;
                        busy       <= 1'b0;
                        sr_data    <= 1'b0;
                    end else begin
                        half_cnt   <= half_cnt - 8'd1;
                        frame_done <= (half_cnt == 8'd1);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                end
                default: begin
                    state   <= ST_GAP;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule
